// File: rtl/pwm_timebase_controller_pkg.sv
// Shared types and constants for the PWM timebase controller.
// Imported by the interface, the period counter and the top level.
package pwm_timebase_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam int PHASE_IDX_W = 3;
    localparam int PHASE_EXT_W = PHASE_IDX_W + 1;

endpackage

// File: rtl/pwm_timebase_controller_if.sv
// Host-side and pwm-bank-side signal bundle of the timebase controller.
// Write/commit/clear are single-cycle pulses sampled on every rising clock; there is no back-pressure,
// update_ack is a one-cycle registered pulse after each accepted write.
interface pwm_timebase_controller_if
    import pwm_timebase_controller_pkg::*;
#(
    parameter int bitwidth    = 8,
    parameter int phase_count = 3
) ();

    logic                            enable;
    logic [bitwidth-1:0]             period;
    logic                            update_request;
    logic [PHASE_IDX_W-1:0]          update_phase;
    logic [bitwidth-1:0]             update_highside;
    logic [bitwidth-1:0]             update_lowside;
    logic                            update_ack;
    logic                            commit_request;
    logic                            commit_pending;
    logic                            error_clear;
    logic                            error_output;
    logic [bitwidth-1:0]             tick_counter;
    logic                            load_enable;
    logic [phase_count*bitwidth-1:0] tick_count_highside;
    logic [phase_count*bitwidth-1:0] tick_count_lowside;
    logic                            period_start;
    logic                            running;
    state_t                          fsm_state;

    modport master (
        output enable, period, update_request, update_phase, update_highside, update_lowside,
               commit_request, error_clear,
        input  update_ack, commit_pending, error_output, tick_counter, load_enable,
               tick_count_highside, tick_count_lowside, period_start, running, fsm_state
    );

    modport slave (
        input  enable, period, update_request, update_phase, update_highside, update_lowside,
               commit_request, error_clear,
        output update_ack, commit_pending, error_output, tick_counter, load_enable,
               tick_count_highside, tick_count_lowside, period_start, running, fsm_state
    );

endinterface

// File: rtl/pwm_timebase_controller_period_counter.sv
// Shared tick counter and active period register; counts 0..period_active and flags the wrap cycle.
// period_active is only ever reloaded at a wrap, so the counter never runs past a shortened period.
module pwm_timebase_controller_period_counter #(
    parameter int bitwidth       = 8,
    parameter int default_period = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                counting,
    input  logic                wrap_allowed,
    input  logic [bitwidth-1:0] period,
    output logic [bitwidth-1:0] tick_counter,
    output logic [bitwidth-1:0] next_period,
    output logic                at_top,
    output logic                wrap
);

    logic [bitwidth-1:0] period_active;

    // A zero period would make the counter stick at 0, so it is promoted to 1.
    assign next_period = (period == '0) ? bitwidth'(1) : period;
    assign at_top      = (tick_counter == period_active);
    assign wrap        = at_top && wrap_allowed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_counter  <= bitwidth'(default_period);
            period_active <= bitwidth'(default_period);
        end else if (wrap) begin
            tick_counter  <= '0;
            period_active <= next_period;
        end else if (counting && !at_top) begin
            tick_counter  <= tick_counter + bitwidth'(1);
        end
    end

endmodule

// File: rtl/pwm_timebase_controller.sv
// Timebase sequencer for a bank of PWM half bridges: run/stop FSM, staging bank,
// atomic commit of staged duty values at period start, and sticky error flag.
module pwm_timebase_controller
    import pwm_timebase_controller_pkg::*;
#(
    parameter int bitwidth       = 8,
    parameter int phase_count    = 3,
    parameter int default_period = 255
) (
    input logic                     clock,
    input logic                     reset,
    pwm_timebase_controller_if.slave bus
);

    state_t                          state, state_next;
    logic [bitwidth-1:0]             tick_counter, next_period;
    logic                            at_top, wrap, counting, wrap_allowed;
    logic [bitwidth-1:0]             stage_hi [phase_count];
    logic [bitwidth-1:0]             stage_lo [phase_count];
    logic [phase_count*bitwidth-1:0] live_hi, live_lo;
    logic                            commit_pending, commit_fire, commit_ok;
    logic                            write_bad, new_error, error_flag;
    logic                            update_ack, load_enable;

    assign counting     = (state != ST_IDLE);
    // Leaving IDLE is itself a wrap; STOPPING only wraps again if enable came back.
    assign wrap_allowed = (state == ST_RUN) || bus.enable;

    pwm_timebase_controller_period_counter #(
        .bitwidth       (bitwidth),
        .default_period (default_period)
    ) u_period_counter (
        .clock        (clock),
        .reset        (reset),
        .counting     (counting),
        .wrap_allowed (wrap_allowed),
        .period       (bus.period),
        .tick_counter (tick_counter),
        .next_period  (next_period),
        .at_top       (at_top),
        .wrap         (wrap)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (bus.enable) state_next = ST_RUN;
            ST_RUN:      if (!bus.enable) state_next = ST_STOPPING;
            ST_STOPPING: begin
                if (bus.enable)  state_next = ST_RUN;
                else if (at_top) state_next = ST_IDLE;
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    // A request arriving on the wrap cycle itself is honoured at that wrap.
    assign commit_fire = wrap && (commit_pending || bus.commit_request);
    assign write_bad   = bus.update_request &&
                         ({1'b0, bus.update_phase} >= PHASE_EXT_W'(phase_count));
    assign new_error   = write_bad || (commit_fire && !commit_ok);

    // Checked against the period that becomes active at this wrap, not the old one.
    always_comb begin
        commit_ok = 1'b1;
        for (int p = 0; p < phase_count; p++) begin
            if (({1'b0, stage_hi[p]} + {1'b0, stage_lo[p]}) > {1'b0, next_period})
                commit_ok = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < phase_count; p++) begin
                stage_hi[p] <= '0;
                stage_lo[p] <= '0;
            end
        end else if (bus.update_request) begin
            for (int p = 0; p < phase_count; p++) begin
                if (bus.update_phase == PHASE_IDX_W'(p)) begin
                    stage_hi[p] <= bus.update_highside;
                    stage_lo[p] <= bus.update_lowside;
                end
            end
        end
    end

    // Non-blocking copy reads the staging bank as it was before any same-cycle write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live_hi     <= '0;
            live_lo     <= '0;
            load_enable <= 1'b0;
        end else begin
            load_enable <= commit_fire && commit_ok;
            if (commit_fire && commit_ok) begin
                for (int p = 0; p < phase_count; p++) begin
                    live_hi[p*bitwidth +: bitwidth] <= stage_hi[p];
                    live_lo[p*bitwidth +: bitwidth] <= stage_lo[p];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_pending <= 1'b0;
            error_flag     <= 1'b0;
            update_ack     <= 1'b0;
        end else begin
            update_ack <= bus.update_request;
            if (commit_fire)             commit_pending <= 1'b0;
            else if (bus.commit_request) commit_pending <= 1'b1;
            if (new_error)               error_flag <= 1'b1;
            else if (bus.error_clear)    error_flag <= 1'b0;
        end
    end

    assign bus.update_ack          = update_ack;
    assign bus.commit_pending      = commit_pending;
    assign bus.error_output        = error_flag;
    assign bus.tick_counter        = tick_counter;
    assign bus.load_enable         = load_enable;
    assign bus.tick_count_highside = live_hi;
    assign bus.tick_count_lowside  = live_lo;
    assign bus.period_start        = counting && (tick_counter == '0);
    assign bus.running             = counting;
    assign bus.fsm_state           = state;

endmodule

// File: tb/tb_pwm_timebase_controller.sv
// Directed bench for pwm_timebase_controller: expected acks and commit loads are queued by the
// stimulus and popped by a negedge monitor; state/counter values are checked inline.
module tb_pwm_timebase_controller;
    import pwm_timebase_controller_pkg::*;

    localparam int BW = 8;
    localparam int PC = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] load_exp_q [$];
    logic [63:0] ack_exp_q  [$];

    always #5 clock = ~clock;

    pwm_timebase_controller_if #(.bitwidth(BW), .phase_count(PC)) bus ();

    pwm_timebase_controller #(
        .bitwidth       (BW),
        .phase_count    (PC),
        .default_period (255)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_phase(input logic [2:0] ph, input logic [7:0] hi, input logic [7:0] lo,
                               input logic exp_err);
        bus.update_request  = 1'b1;
        bus.update_phase    = ph;
        bus.update_highside = hi;
        bus.update_lowside  = lo;
        ack_exp_q.push_back(64'(exp_err));
        step();
        bus.update_request  = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.commit_request = 1'b1;
        step();
        bus.commit_request = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.error_clear = 1'b1;
        step();
        bus.error_clear = 1'b0;
    endtask

    task automatic wait_tick(input logic [7:0] v, input string name);
        int n = 0;
        while (bus.tick_counter !== v && n < 40) begin
            step();
            n++;
        end
        check(name, 64'(bus.tick_counter), 64'(v));
    endtask

    // Monitor: every ack and every load pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.update_ack) begin
                if (ack_exp_q.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
                else check("ack_error_flag", 64'(bus.error_output), ack_exp_q.pop_front());
            end
            if (bus.load_enable) begin
                if (load_exp_q.size() == 0) check("unexpected_load", 64'd1, 64'd0);
                else check("load_values",
                           64'({bus.tick_counter, bus.tick_count_highside, bus.tick_count_lowside}),
                           load_exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 0; bus.period = 8'd9; bus.update_request = 0; bus.update_phase = 0;
        bus.update_highside = 0; bus.update_lowside = 0; bus.commit_request = 0; bus.error_clear = 0;
        step(2);
        reset = 1'b0;
        step();

        // Reset state, IDLE holding the default period
        check("rst_tick", 64'(bus.tick_counter), 64'd255);
        check("rst_load", 64'(bus.load_enable), 64'd0);
        check("rst_running", 64'(bus.running), 64'd0);
        check("rst_hi", 64'(bus.tick_count_highside), 64'd0);
        check("rst_lo", 64'(bus.tick_count_lowside), 64'd0);
        check("rst_pending", 64'(bus.commit_pending), 64'd0);
        check("rst_error", 64'(bus.error_output), 64'd0);
        check("rst_state", 64'(bus.fsm_state), 64'(ST_IDLE));
        step(3);
        check("idle_hold", 64'(bus.tick_counter), 64'd255);

        // Commit pending in IDLE applies at the IDLE->RUN wrap
        write_phase(3'd0, 8'd3, 8'd4, 1'b0);
        pulse_commit();
        check("pending_set", 64'(bus.commit_pending), 64'd1);
        load_exp_q.push_back(64'({8'd0, 24'h000003, 24'h000004}));
        bus.enable = 1'b1;
        step();
        check("start_tick", 64'(bus.tick_counter), 64'd0);
        check("start_load", 64'(bus.load_enable), 64'd1);
        check("start_running", 64'(bus.running), 64'd1);
        check("start_pstart", 64'(bus.period_start), 64'd1);
        check("start_pending", 64'(bus.commit_pending), 64'd0);
        check("start_hi", 64'(bus.tick_count_highside), 64'h000003);
        check("start_lo", 64'(bus.tick_count_lowside), 64'h000004);
        for (int k = 1; k <= 20; k++) begin
            step();
            check("count_seq", 64'(bus.tick_counter), 64'(k % 10));
            check("pstart_seq", 64'(bus.period_start), 64'((k % 10) == 0));
        end

        // Commit that does not fit the period is rejected at the wrap
        wait_tick(8'd2, "wait_t2");
        write_phase(3'd0, 8'd6, 8'd5, 1'b0);
        pulse_commit();
        check("rej_pending", 64'(bus.commit_pending), 64'd1);
        wait_tick(8'd0, "wait_rej_wrap");
        check("rej_error", 64'(bus.error_output), 64'd1);
        check("rej_pending_clr", 64'(bus.commit_pending), 64'd0);
        check("rej_load", 64'(bus.load_enable), 64'd0);
        check("rej_hi", 64'(bus.tick_count_highside), 64'h000003);
        check("rej_lo", 64'(bus.tick_count_lowside), 64'h000004);
        pulse_clear();
        check("clear_error", 64'(bus.error_output), 64'd0);

        // Bad phase index: acked, flags error, leaves staging untouched
        write_phase(3'd0, 8'd2, 8'd3, 1'b0);
        write_phase(3'd1, 8'd1, 8'd2, 1'b0);
        write_phase(3'd5, 8'd9, 8'd9, 1'b1);
        check("badidx_error", 64'(bus.error_output), 64'd1);
        pulse_clear();
        check("badidx_clear", 64'(bus.error_output), 64'd0);
        pulse_commit();
        load_exp_q.push_back(64'({8'd0, 24'h000102, 24'h000203}));
        wait_tick(8'd0, "wait_ok_wrap");
        check("ok_load", 64'(bus.load_enable), 64'd1);
        check("ok_hi", 64'(bus.tick_count_highside), 64'h000102);
        check("ok_lo", 64'(bus.tick_count_lowside), 64'h000203);
        check("ok_error", 64'(bus.error_output), 64'd0);

        // enable drop at 4: finish the period, then hold in IDLE
        wait_tick(8'd4, "wait_t4");
        bus.enable = 1'b0;
        step();
        check("stop_tick5", 64'(bus.tick_counter), 64'd5);
        check("stop_state", 64'(bus.fsm_state), 64'(ST_STOPPING));
        check("stop_running", 64'(bus.running), 64'd1);
        step(4);
        check("stop_tick9", 64'(bus.tick_counter), 64'd9);
        check("stop_run9", 64'(bus.running), 64'd1);
        step();
        check("idle_tick", 64'(bus.tick_counter), 64'd9);
        check("idle_running", 64'(bus.running), 64'd0);
        step(3);
        check("idle_hold9", 64'(bus.tick_counter), 64'd9);
        check("idle_pstart", 64'(bus.period_start), 64'd0);

        // Re-enable inside STOPPING continues counting without a glitch
        bus.enable = 1'b1;
        step();
        check("restart_tick", 64'(bus.tick_counter), 64'd0);
        wait_tick(8'd4, "wait_t4b");
        bus.enable = 1'b0;
        step(3);
        check("stop2_tick7", 64'(bus.tick_counter), 64'd7);
        check("stop2_state", 64'(bus.fsm_state), 64'(ST_STOPPING));
        bus.enable = 1'b1;
        step();
        check("resume_tick8", 64'(bus.tick_counter), 64'd8);
        check("resume_state", 64'(bus.fsm_state), 64'(ST_RUN));
        step();
        check("resume_tick9", 64'(bus.tick_counter), 64'd9);
        step();
        check("resume_tick0", 64'(bus.tick_counter), 64'd0);
        step();
        check("resume_tick1", 64'(bus.tick_counter), 64'd1);

        // period=0 is treated as 1
        bus.period = 8'd0;
        wait_tick(8'd0, "wait_p0_wrap");
        step();
        check("p0_tick1", 64'(bus.tick_counter), 64'd1);
        bus.period = 8'd9;
        step();
        check("p0_tick0", 64'(bus.tick_counter), 64'd0);
        check("p0_pstart", 64'(bus.period_start), 64'd1);
        step();
        check("p9_tick1", 64'(bus.tick_counter), 64'd1);

        // Asynchronous reset in the middle of a pending commit
        wait_tick(8'd3, "wait_t3");
        write_phase(3'd2, 8'd1, 8'd1, 1'b0);
        pulse_commit();
        check("mid_tick5", 64'(bus.tick_counter), 64'd5);
        check("mid_pending", 64'(bus.commit_pending), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tick", 64'(bus.tick_counter), 64'd255);
        check("arst_pending", 64'(bus.commit_pending), 64'd0);
        check("arst_running", 64'(bus.running), 64'd0);
        check("arst_hi", 64'(bus.tick_count_highside), 64'd0);
        check("arst_lo", 64'(bus.tick_count_lowside), 64'd0);
        check("arst_state", 64'(bus.fsm_state), 64'(ST_IDLE));
        step(2);
        bus.enable = 1'b0;
        reset = 1'b0;
        step(2);
        check("post_rst_tick", 64'(bus.tick_counter), 64'd255);
        check("post_rst_load", 64'(bus.load_enable), 64'd0);

        check("ack_q_empty", 64'(ack_exp_q.size()), 64'd0);
        check("load_q_empty", 64'(load_exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
